vga_frame_receiver: RTL and testbench
=====================================

// Module: vga_frame_receiver
// PURPOSE
//  Receive end of the VGA link: samples hsync/vsync/rgb from a 640x480 pixel stream and locks to its timing.
//  Regenerates active_area/coord_x/coord_y for downstream checkers, and measures the first white run on one line per frame.
//  Sits on the capture/loopback side of the display path and closes the generator loop in self-test.
//  Stream is one pixel per clk; hsync and vsync are active-low.
// PARAMETERS
//  H_SYNC      96   hsync low width, pixels
//  H_BP        48   horizontal back porch, pixels
//  H_ACTIVE    640  visible pixels per line
//  H_TOTAL     800  pixels per line
//  V_SYNC      2    vsync low width, lines
//  V_BP        33   vertical back porch, lines
//  V_ACTIVE    480  visible lines
//  V_TOTAL     525  lines per frame
//  MEAS_LINE   240  active line (coord_y) used for bar measurement
//  LOCK_FRAMES 2    consecutive good frames needed to assert locked
// PORTS
//  clk          in   1   pixel clock
//  reset        in   1   asynchronous, active-high
//  hsync        in   1   active-low horizontal sync
//  vsync        in   1   active-low vertical sync
//  rgb          in   3   pixel colour, sampled every clk
//  locked       out  1   timing lock established
//  sync_err     out  1   1-cycle pulse: line/frame length mismatch
//  active_area  out  1   registered pixel is visible (0 when !locked)
//  coord_x      out  10  visible x, 0..H_ACTIVE-1 (0 outside active)
//  coord_y      out  10  visible y, 0..V_ACTIVE-1 (0 outside active)
//  rgb_q        out  3   registered rgb, aligned with coord_x/coord_y
//  bar_x        out  10  x of first white pixel on MEAS_LINE
//  bar_w        out  10  length of that contiguous white run
//  no_bar       out  1   no white pixel found on MEAS_LINE
//  bar_valid    out  1   1-cycle pulse: bar_x/bar_w/no_bar updated
// BEHAVIOUR
//  Reset: every output is 0, FSM = SEARCH, counters = 0, and the previous-sync registers are 1.
//  Edges: fall = previous sample 1 and current sample 0. hcnt = 0 in the cycle hsync is first sampled low; otherwise hcnt increments (saturates at 1023).
//  vcnt = 0 on the hsync fall of the line where vsync is first sampled low. It increments on each later hsync fall, and the vsync fall takes priority.
//  Checks:
//   - Line check at each hsync fall: the previous hcnt must equal H_TOTAL-1.
//   - Frame check at each vsync fall: the previous vcnt must equal V_TOTAL-1.
//  FSM:
//   - SEARCH: on the first vsync fall -> CHECK with good=0.
//   - CHECK: each frame that passes increments good. When good reaches LOCK_FRAMES -> LOCKED (locked=1 from the next cycle). Any failure resets good to 0 and stays in CHECK.
//   - LOCKED: any failure -> sync_err pulse, locked=0, go to SEARCH. A failure in CHECK does not raise sync_err.
//  Output stage: registered, with 1 clk latency from the rgb/hsync sample to coord/rgb_q.
//   - active = locked && hcnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) && vcnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
//   - coord_x = hcnt-(H_SYNC+H_BP) and coord_y = vcnt-(V_SYNC+V_BP) when active; both 0 otherwise.
//  Bar measurement (only while locked, on the line where coord_y == MEAS_LINE):
//   - The run starts at the first active pixel with rgb == 3'b111, and bar_x latches that coord_x.
//   - The run ends at the first non-white pixel or at the end of the active line; bar_w is the count of white pixels in it.
//   - Later runs on the same line are ignored.
//  Report: bar_valid pulses in the cycle vcnt first reaches V_SYNC+V_BP+V_ACTIVE (start of vertical blanking). No white seen -> no_bar=1, bar_x=0, bar_w=0.
//  Bar outputs hold until the next report. A loss of lock mid-frame discards the pending measurement (no pulse).
//  Reset mid-frame: relock requires a vsync fall plus LOCK_FRAMES full frames. Outputs are 0 immediately on reset assertion.
// TESTING
//  Nominal 800x525 timing, all black: locked rises after vsync fall + 2 frames; bar_valid each frame with no_bar=1; sync_err never pulses.
//  White on line 240, x=100..139: bar_valid, bar_x=100, bar_w=40, no_bar=0; coord_x=100 exactly when rgb_q first = 3'b111.
//  White x=620..639 on line 240, plus a second run at x=10..19 on line 240: bar_x=10, bar_w=10. Then the 620 run alone: bar_x=620, bar_w=20.
//  Once locked, shorten one line to 799 pixels: sync_err pulses once and locked=0. Relock after 2 clean frames.
//  Assert reset at line 300: all outputs 0 in the same cycle. After release, locked returns only after vsync fall + 2 good frames.
//  Corner pixel checks: active_area=1 with coord=(0,0) for hcnt=144, vcnt=35; active_area=0 at hcnt=784 and at vcnt=515.

Source files
------------

// File: rtl/vga_frame_receiver_if.sv
// VGA receive-link bundle.
// The generator side (master) drives hsync/vsync/rgb and observes everything
// the receiver regenerates; the receiver (slave) does the reverse.
//   hsync, vsync  active-low syncs, one pixel per clk
//   rgb           3-bit pixel colour
//   locked        timing lock established
//   sync_err      1-cycle pulse on line/frame length mismatch while locked
//   active_area   registered pixel is visible
//   coord_x/y     visible coordinates of the registered pixel
//   rgb_q         registered rgb, aligned with coord_x/coord_y
//   bar_x/bar_w   first white run on the measurement line
//   no_bar        no white pixel found on the measurement line
//   bar_valid     1-cycle pulse: bar outputs updated
interface vga_frame_receiver_if;
    logic       hsync;
    logic       vsync;
    logic [2:0] rgb;
    logic       locked;
    logic       sync_err;
    logic       active_area;
    logic [9:0] coord_x;
    logic [9:0] coord_y;
    logic [2:0] rgb_q;
    logic [9:0] bar_x;
    logic [9:0] bar_w;
    logic       no_bar;
    logic       bar_valid;

    modport master (
        output hsync, vsync, rgb,
        input  locked, sync_err, active_area, coord_x, coord_y, rgb_q,
               bar_x, bar_w, no_bar, bar_valid
    );

    modport slave (
        input  hsync, vsync, rgb,
        output locked, sync_err, active_area, coord_x, coord_y, rgb_q,
               bar_x, bar_w, no_bar, bar_valid
    );
endinterface

// File: rtl/vga_frame_receiver.sv
// Receive end of the VGA link. Locks to the incoming hsync/vsync timing,
// regenerates active_area/coord_x/coord_y with one clk of latency, and
// measures the first white run on one chosen line of every locked frame.
// Ports:
//   clk    pixel clock
//   reset  asynchronous, active-high
//   vga    vga_frame_receiver_if.slave (stream in, timing/bar results out)
//
// state  | meaning
// -------+----------------------------------------------------------
// SEARCH | waiting for the first vsync fall to align the frame count
// CHECK  | counting consecutive good frames towards lock
// LOCKED | timing trusted; outputs live, any mismatch drops lock
module vga_frame_receiver #(
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int H_ACTIVE    = 640,
    parameter int H_TOTAL     = 800,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int V_ACTIVE    = 480,
    parameter int V_TOTAL     = 525,
    parameter int MEAS_LINE   = 240,
    parameter int LOCK_FRAMES = 2
) (
    input logic                 clk,
    input logic                 reset,
    vga_frame_receiver_if.slave vga
);

    localparam logic [9:0] H_START = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_END   = 10'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_START = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_END   = 10'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] MEAS_V  = 10'(V_SYNC + V_BP + MEAS_LINE);
    localparam logic [3:0] LOCK_N  = 4'(LOCK_FRAMES);
    localparam logic [9:0] CNT_MAX = 10'd1023;

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

    state_t     state;
    logic [3:0] good;
    logic       frame_bad;   // a line failed somewhere in the frame being checked
    logic       hs_prev, vs_prev;
    logic       vs_pend;     // vsync fell mid-line; restart vcnt on the next hsync fall
    logic [9:0] hcnt, vcnt;

    logic       meas_seen, meas_run;
    logic [9:0] acc_x, acc_w;

    logic       locked_q, sync_err_q, active_q, no_bar_q, bar_valid_q;
    logic [9:0] coord_x_q, coord_y_q, bar_x_q, bar_w_q;
    logic [2:0] rgb_q_q;

    logic       hs_fall, vs_fall;
    logic [9:0] hcnt_nxt, vcnt_nxt, x_nxt;
    logic       line_bad, frame_len_bad, fail_now, lock_ok;
    logic       active_nxt, on_meas, white, report;

    always_comb begin
        hs_fall  = hs_prev & ~vga.hsync;
        vs_fall  = vs_prev & ~vga.vsync;

        hcnt_nxt = hcnt;
        if (hs_fall)
            hcnt_nxt = '0;
        else if (hcnt != CNT_MAX)
            hcnt_nxt = hcnt + 10'd1;

        vcnt_nxt = vcnt;
        if (hs_fall) begin
            if (vs_fall || vs_pend)
                vcnt_nxt = '0;
            else if (vcnt != CNT_MAX)
                vcnt_nxt = vcnt + 10'd1;
        end

        line_bad      = hs_fall && (hcnt != H_LAST);
        frame_len_bad = vs_fall && (vcnt != V_LAST);
        fail_now      = line_bad || frame_len_bad;
        // A failing cycle in LOCKED is already the loss of lock, so it must
        // neither extend nor report the pending measurement.
        lock_ok       = (state == LOCKED) && !fail_now;

        active_nxt = locked_q &&
                     (hcnt_nxt >= H_START) && (hcnt_nxt < H_END) &&
                     (vcnt_nxt >= V_START) && (vcnt_nxt < V_END);
        x_nxt      = hcnt_nxt - H_START;
        white      = (vga.rgb == 3'b111);
        on_meas    = active_nxt && (vcnt_nxt == MEAS_V);
        // vcnt only moves on hsync falls, so this fires once per frame.
        report     = hs_fall && (vcnt_nxt == V_END) && (vcnt != V_END);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= SEARCH;
            good        <= '0;
            frame_bad   <= 1'b0;
            hs_prev     <= 1'b1;
            vs_prev     <= 1'b1;
            vs_pend     <= 1'b0;
            hcnt        <= '0;
            vcnt        <= '0;
            meas_seen   <= 1'b0;
            meas_run    <= 1'b0;
            acc_x       <= '0;
            acc_w       <= '0;
            locked_q    <= 1'b0;
            sync_err_q  <= 1'b0;
            active_q    <= 1'b0;
            coord_x_q   <= '0;
            coord_y_q   <= '0;
            rgb_q_q     <= '0;
            bar_x_q     <= '0;
            bar_w_q     <= '0;
            no_bar_q    <= 1'b0;
            bar_valid_q <= 1'b0;
        end else begin
            hs_prev     <= vga.hsync;
            vs_prev     <= vga.vsync;
            hcnt        <= hcnt_nxt;
            vcnt        <= vcnt_nxt;
            sync_err_q  <= 1'b0;
            bar_valid_q <= 1'b0;

            if (hs_fall)
                vs_pend <= 1'b0;
            else if (vs_fall)
                vs_pend <= 1'b1;

            case (state)
                SEARCH: begin
                    if (vs_fall) begin
                        state     <= CHECK;
                        good      <= '0;
                        frame_bad <= 1'b0;
                    end
                end
                CHECK: begin
                    if (vs_fall) begin
                        frame_bad <= 1'b0;
                        if (fail_now || frame_bad) begin
                            good <= '0;
                        end else if (good + 4'd1 == LOCK_N) begin
                            state    <= LOCKED;
                            locked_q <= 1'b1;
                            good     <= '0;
                        end else begin
                            good <= good + 4'd1;
                        end
                    end else if (line_bad) begin
                        good      <= '0;
                        frame_bad <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (fail_now) begin
                        state      <= SEARCH;
                        locked_q   <= 1'b0;
                        sync_err_q <= 1'b1;
                    end
                end
                default: begin
                    state    <= SEARCH;
                    locked_q <= 1'b0;
                end
            endcase

            active_q  <= active_nxt;
            coord_x_q <= active_nxt ? x_nxt : 10'd0;
            coord_y_q <= active_nxt ? (vcnt_nxt - V_START) : 10'd0;
            rgb_q_q   <= vga.rgb;

            if (!lock_ok) begin
                meas_seen <= 1'b0;
                meas_run  <= 1'b0;
            end else if (report) begin
                bar_valid_q <= 1'b1;
                no_bar_q    <= !meas_seen;
                bar_x_q     <= meas_seen ? acc_x : 10'd0;
                bar_w_q     <= meas_seen ? acc_w : 10'd0;
                meas_seen   <= 1'b0;
                meas_run    <= 1'b0;
            end else if (on_meas) begin
                if (!meas_seen && white) begin
                    meas_seen <= 1'b1;
                    meas_run  <= 1'b1;
                    acc_x     <= x_nxt;
                    acc_w     <= 10'd1;
                end else if (meas_run && white) begin
                    acc_w <= acc_w + 10'd1;
                end else begin
                    meas_run <= 1'b0;
                end
            end else begin
                // Leaving the active part of the line closes any open run.
                meas_run <= 1'b0;
            end
        end
    end

    assign vga.locked      = locked_q;
    assign vga.sync_err    = sync_err_q;
    assign vga.active_area = active_q;
    assign vga.coord_x     = coord_x_q;
    assign vga.coord_y     = coord_y_q;
    assign vga.rgb_q       = rgb_q_q;
    assign vga.bar_x       = bar_x_q;
    assign vga.bar_w       = bar_w_q;
    assign vga.no_bar      = no_bar_q;
    assign vga.bar_valid   = bar_valid_q;

endmodule

// File: tb/tb_vga_frame_receiver.sv
// Bench for vga_frame_receiver using a scaled-down raster so that many
// frames fit in a short run. Bar reports are checked by a scoreboard;
// lock, sync_err, corner pixels and reset behaviour by direct checks.
module tb_vga_frame_receiver;

    localparam int HS = 8, HBP = 8, HA = 40, HT = 64;
    localparam int VS = 2, VBP = 3, VA = 10, VT = 20;
    localparam int ML = 4;
    localparam int MEAS_L = VS + VBP + ML;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vga_frame_receiver_if vif();

    vga_frame_receiver #(
        .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA), .H_TOTAL(HT),
        .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA), .V_TOTAL(VT),
        .MEAS_LINE(ML), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .vga(vif)
    );

    typedef struct packed {
        logic       nb;
        logic [9:0] x;
        logic [9:0] w;
    } bar_t;

    bar_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   sync_err_cnt = 0;
    int   chk_en = 0;
    int   prev_l = -1;
    int   prev_p = -1;
    int   first_x = -1;
    int   run_lo[$];
    int   run_hi[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_bar(input logic nb, input int x, input int w);
        bar_t b;
        b.nb = nb;
        b.x  = 10'(x);
        b.w  = 10'(w);
        exp_q.push_back(b);
    endtask

    function automatic logic is_white(input int l, input int p);
        int x;
        x = p - HS - HBP;
        if (l != MEAS_L || x < 0 || x >= HA) return 1'b0;
        foreach (run_lo[i])
            if (x >= run_lo[i] && x <= run_hi[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_locked"},   vif.locked, 0);
        chk({tag, "_sync_err"}, vif.sync_err, 0);
        chk({tag, "_active"},   vif.active_area, 0);
        chk({tag, "_coord_x"},  vif.coord_x, 0);
        chk({tag, "_coord_y"},  vif.coord_y, 0);
        chk({tag, "_rgb_q"},    vif.rgb_q, 0);
        chk({tag, "_bar_x"},    vif.bar_x, 0);
        chk({tag, "_bar_w"},    vif.bar_w, 0);
        chk({tag, "_no_bar"},   vif.no_bar, 0);
        chk({tag, "_bar_valid"}, vif.bar_valid, 0);
    endtask

    // Outputs visible at this negedge belong to pixel (l, p).
    task automatic check_pixel(input int l, input int p);
        if (l == VS + VBP && p == HS + HBP) begin
            chk("corner00_active", vif.active_area, 1);
            chk("corner00_x", vif.coord_x, 0);
            chk("corner00_y", vif.coord_y, 0);
        end
        if (l == VS + VBP && p == HS + HBP - 1)
            chk("pre_h_active", vif.active_area, 0);
        if (l == VS + VBP && p == HS + HBP + HA)
            chk("post_h_active", vif.active_area, 0);
        if (l == VS + VBP + VA - 1 && p == HS + HBP + HA - 1) begin
            chk("corner_last_active", vif.active_area, 1);
            chk("corner_last_x", vif.coord_x, HA - 1);
            chk("corner_last_y", vif.coord_y, VA - 1);
        end
        if (l == VS + VBP + VA && p == HS + HBP + 20) begin
            chk("post_v_active", vif.active_area, 0);
            chk("post_v_x", vif.coord_x, 0);
        end
        if (first_x >= 0 && l == MEAS_L && p == HS + HBP + first_x) begin
            chk("first_white_rgb", vif.rgb_q, 7);
            chk("first_white_x", vif.coord_x, first_x);
            chk("first_white_y", vif.coord_y, ML);
        end
        if (first_x > 0 && l == MEAS_L && p == HS + HBP + first_x - 1)
            chk("before_white_rgb", vif.rgb_q, 0);
    endtask

    task automatic run_frame(input int short_line, input int rst_line);
        int len;
        for (int l = 0; l < VT; l++) begin
            len = (l == short_line) ? HT - 1 : HT;
            for (int p = 0; p < len; p++) begin
                @(negedge clk);
                if (chk_en != 0 && prev_l >= 0) check_pixel(prev_l, prev_p);
                if (l == rst_line && p == 20) begin
                    chk("pre_reset_active", vif.active_area, 1);
                    chk("pre_reset_bar_x", vif.bar_x, 10);
                end
                vif.hsync = (p >= HS);
                vif.vsync = (l >= VS);
                vif.rgb   = is_white(l, p) ? 3'b111 : 3'b000;
                prev_l = l;
                prev_p = p;
                if (l == rst_line && p == 20) begin
                    #2 reset = 1'b1;
                    #1 check_zero("midreset");
                end
                if (l == rst_line && p == 30) reset = 1'b0;
            end
        end
    endtask

    task automatic set_run(input int lo, input int hi);
        run_lo.push_back(lo);
        run_hi.push_back(hi);
    endtask

    task automatic clear_runs();
        run_lo.delete();
        run_hi.delete();
        first_x = -1;
    endtask

    // Scoreboard monitor: every bar_valid pops one expected report.
    always @(negedge clk) begin
        bar_t e;
        if (vif.sync_err === 1'b1) sync_err_cnt++;
        if (vif.bar_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("bar_unexpected", vif.bar_valid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("no_bar", vif.no_bar, e.nb);
                chk("bar_x", vif.bar_x, e.x);
                chk("bar_w", vif.bar_w, e.w);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before end of sequence");
        $fatal(1, "watchdog");
    end

    initial begin
        vif.hsync = 1'b1;
        vif.vsync = 1'b1;
        vif.rgb   = 3'b000;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        repeat (5) @(negedge clk);

        clear_runs();
        run_frame(-1, -1);
        run_frame(-1, -1);
        chk("locked_after_2", vif.locked, 0);

        chk_en = 1;
        push_bar(1'b1, 0, 0);
        run_frame(-1, -1);
        chk("locked_after_3", vif.locked, 1);

        set_run(10, 19); first_x = 10;
        push_bar(1'b0, 10, 10);
        run_frame(-1, -1);

        clear_runs();
        set_run(30, 39); set_run(2, 5); first_x = 2;
        push_bar(1'b0, 2, 4);
        run_frame(-1, -1);

        clear_runs();
        set_run(30, 39); first_x = 30;
        push_bar(1'b0, 30, 10);
        run_frame(-1, -1);
        chk("sync_err_none", sync_err_cnt, 0);
        chk("still_locked", vif.locked, 1);

        chk_en = 0;
        clear_runs();
        run_frame(7, -1);
        chk("sync_err_once", sync_err_cnt, 1);
        chk("lock_lost", vif.locked, 0);
        run_frame(-1, -1);
        run_frame(-1, -1);
        chk("relock_not_yet", vif.locked, 0);
        chk_en = 1;
        set_run(10, 19); first_x = 10;
        push_bar(1'b0, 10, 10);
        run_frame(-1, -1);
        chk("relocked", vif.locked, 1);

        chk_en = 0;
        run_frame(-1, 12);
        chk("post_reset_unlocked", vif.locked, 0);
        clear_runs();
        run_frame(-1, -1);
        run_frame(-1, -1);
        chk("reset_relock_not_yet", vif.locked, 0);
        chk_en = 1;
        set_run(2, 5); first_x = 2;
        push_bar(1'b0, 2, 4);
        run_frame(-1, -1);
        chk("reset_relocked", vif.locked, 1);
        chk("sync_err_total", sync_err_cnt, 1);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
